// File: rtl/w0rm_alu_pkg.sv
// Shared constants for the ALU dispatch slice: opcodes, flag positions, FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package w0rm_alu_pkg;

  // ALU opcodes as seen on op_opcode / fu_opcode
  localparam logic [3:0] ALU_OPCODE_AND = 4'h0;
  localparam logic [3:0] ALU_OPCODE_OR  = 4'h1;
  localparam logic [3:0] ALU_OPCODE_XOR = 4'h2;
  localparam logic [3:0] ALU_OPCODE_NOT = 4'h3;
  localparam logic [3:0] ALU_OPCODE_NEG = 4'h4;
  localparam logic [3:0] ALU_OPCODE_DIV = 4'h8;
  localparam logic [3:0] ALU_OPCODE_REM = 4'h9;

  // Bit positions inside the 4-bit flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Flags reported for a divide/remainder by zero: overflow plus zero result
  localparam logic [3:0] DBZ_FLAGS = 4'((1 << FLAG_V) | (1 << FLAG_Z));

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_FAULT = 3'd4
  } dispatch_state_t;

  // True for the opcodes that must not be issued with a zero divisor
  function automatic logic is_div_op(input logic [3:0] opcode);
    return (opcode == ALU_OPCODE_DIV) || (opcode == ALU_OPCODE_REM);
  endfunction

endpackage

// File: rtl/w0rm_dispatch_timeout.sv
// Watchdog counter for the WAIT state: cleared on load, counts while inc, flags the last allowed cycle.
// Latency: expire is combinational from the count; the count updates one cycle after load/inc.
// Backpressure: none; purely observes the dispatch FSM.
module w0rm_dispatch_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count WAIT cycles; saturate at the last value so a stuck inc cannot wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc && (count != LAST_CNT)) begin
      count <= count + 8'd1;
    end
  end

  // Expire only while counting, in the final permitted WAIT cycle
  assign expire = inc && (count == LAST_CNT);

endmodule

// File: rtl/w0rm_alu_dispatch.sv
// Dispatches one decoded ALU op to a multi-cycle unit, waits for its result and hands it to writeback.
// Latency: issue 1 cycle after accept, wb_valid 1 cycle after fu_result_valid; divide-by-zero wb_valid 1 cycle after accept.
// Backpressure: op_ready only in IDLE with no fault; wb payload held stable while wb_ready is low.
module w0rm_alu_dispatch
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [3:0]                op_opcode,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  input  logic [REG_ADDR_WIDTH-1:0] op_dest,
  output logic                      fu_data_valid,
  output logic [3:0]                fu_opcode,
  output logic [DATA_WIDTH-1:0]     fu_data_a,
  output logic [DATA_WIDTH-1:0]     fu_data_b,
  input  logic [DATA_WIDTH-1:0]     fu_result,
  input  logic                      fu_result_valid,
  input  logic [3:0]                fu_result_flags,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [3:0]                wb_flags,
  output logic                      busy,
  output logic                      fault,
  input  logic                      fault_clear
);

  dispatch_state_t state_q, state_d;

  logic                      fault_q;
  logic [3:0]                opcode_q;
  logic [DATA_WIDTH-1:0]     a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]     wb_dat_q;
  logic [3:0]                wb_flags_q;

  logic idle_rdy;
  logic op_hs;
  logic dbz;
  logic res_capture;
  logic fault_set;
  logic fault_clr;
  logic tmo_load;
  logic tmo_inc;
  logic tmo_expire;

  // A zero divisor is resolved locally instead of being sent to the unit
  assign dbz = is_div_op(op_opcode) && (op_b == '0);

  w0rm_dispatch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmo_load),
    .inc     (tmo_inc),
    .expire  (tmo_expire)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d       = state_q;
    idle_rdy      = 1'b0;
    op_hs         = 1'b0;
    fu_data_valid = 1'b0;
    wb_valid      = 1'b0;
    tmo_load      = 1'b0;
    tmo_inc       = 1'b0;
    res_capture   = 1'b0;
    fault_set     = 1'b0;
    fault_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_rdy = !fault_q;
        if (op_valid && !fault_q) begin
          op_hs   = 1'b1;
          state_d = dbz ? ST_WB : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fu_data_valid = 1'b1;
        tmo_load      = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_inc = 1'b1;
        // A result in the last allowed cycle still counts: it is checked first
        if (fu_result_valid) begin
          res_capture = 1'b1;
          state_d     = ST_WB;
        end else if (tmo_expire) begin
          fault_set = 1'b1;
          state_d   = ST_FAULT;
        end
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          fault_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky fault flag, only cleared from the FAULT state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  // Operation latch and writeback payload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      wb_dat_q   <= '0;
      wb_flags_q <= '0;
    end else begin
      if (op_hs) begin
        opcode_q <= op_opcode;
        a_q      <= op_a;
        b_q      <= op_b;
        dest_q   <= op_dest;
        if (dbz) begin
          wb_dat_q   <= '0;
          wb_flags_q <= DBZ_FLAGS;
        end
      end
      if (res_capture) begin
        wb_dat_q   <= fu_result;
        wb_flags_q <= fu_result_flags;
      end
    end
  end

  // op_ready must read 0 while reset is held, even though the state is IDLE
  assign op_ready  = idle_rdy && reset_n;
  assign fu_opcode = opcode_q;
  assign fu_data_a = a_q;
  assign fu_data_b = b_q;
  assign wb_dest   = dest_q;
  assign wb_data   = wb_dat_q;
  assign wb_flags  = wb_flags_q;
  assign busy      = (state_q != ST_IDLE);
  assign fault     = fault_q;

endmodule

// File: tb/tb_w0rm_alu_dispatch.sv
module tb_w0rm_alu_dispatch;

  localparam int TMO = 8;
  localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_XOR = 4'h2, OP_NOT = 4'h3,
                         OP_NEG = 4'h4, OP_DIV = 4'h8, OP_REM = 4'h9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_opcode = '0;
  logic [7:0] op_a = '0, op_b = '0;
  logic [3:0] op_dest = '0;
  logic       fu_data_valid;
  logic [3:0] fu_opcode;
  logic [7:0] fu_data_a, fu_data_b;
  logic [7:0] fu_result = '0;
  logic       fu_result_valid = 1'b0;
  logic [3:0] fu_result_flags = '0;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [3:0] wb_dest;
  logic [7:0] wb_data;
  logic [3:0] wb_flags;
  logic       busy, fault;
  logic       fault_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         acc_rdy;
    int         fu_cnt;
    int         fu_cyc;
    logic [3:0] fu_op;
    logic [7:0] fu_a, fu_b;
    int         wb_cyc;
    int         fault_cyc;
    logic [7:0] wb_dat;
    logic [3:0] wb_flg;
    logic [3:0] wb_dst;
    bit         stall_bad;
    bit         post_idle;
  } obs_t;

  always #5 clk = ~clk;

  w0rm_alu_dispatch #(
    .DATA_WIDTH     (8),
    .REG_ADDR_WIDTH (4),
    .TIMEOUT        (TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_opcode       (op_opcode),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_dest         (op_dest),
    .fu_data_valid   (fu_data_valid),
    .fu_opcode       (fu_opcode),
    .fu_data_a       (fu_data_a),
    .fu_data_b       (fu_data_b),
    .fu_result       (fu_result),
    .fu_result_valid (fu_result_valid),
    .fu_result_flags (fu_result_flags),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_dest         (wb_dest),
    .wb_data         (wb_data),
    .wb_flags        (wb_flags),
    .busy            (busy),
    .fault           (fault),
    .fault_clear     (fault_clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural functional unit: what a correct ALU would return
  function automatic logic [7:0] alu_ref(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
    case (opc)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_NEG:  return 8'(-a);
      OP_DIV:  return (b == 0) ? 8'h00 : a / b;
      OP_REM:  return (b == 0) ? 8'h00 : a % b;
      default: return 8'h00;
    endcase
  endfunction

  // Drives one op (accept = cycle 0), plays the unit answering k cycles after the strobe
  // (k=0: never), stalls writeback for 'stall' extra cycles, and records what it saw.
  task automatic drive_op(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] dest, input int k, input logic [7:0] res,
                          input logic [3:0] flg, input int stall, output obs_t o);
    o.fu_cnt = 0; o.fu_cyc = -1; o.wb_cyc = -1; o.fault_cyc = -1;
    o.fu_op = '0; o.fu_a = '0; o.fu_b = '0; o.wb_dat = '0; o.wb_flg = '0; o.wb_dst = '0;
    o.stall_bad = 1'b0; o.post_idle = 1'b0;
    op_valid = 1'b1; op_opcode = opc; op_a = a; op_b = b; op_dest = dest;
    o.acc_rdy = op_ready;
    tick();
    op_valid = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      fu_result_valid = 1'b0;
      if (fu_data_valid) begin
        o.fu_cnt++; o.fu_cyc = cyc; o.fu_op = fu_opcode; o.fu_a = fu_data_a; o.fu_b = fu_data_b;
      end
      if (fault) begin
        o.fault_cyc = cyc;
        break;
      end
      if (wb_valid) begin
        o.wb_cyc = cyc; o.wb_dat = wb_data; o.wb_flg = wb_flags; o.wb_dst = wb_dest;
        for (int s = 0; s < stall; s++) begin
          tick();
          if (wb_valid !== 1'b1 || wb_data !== o.wb_dat || wb_flags !== o.wb_flg ||
              wb_dest !== o.wb_dst || op_ready !== 1'b0)
            o.stall_bad = 1'b1;
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        o.post_idle = (wb_valid === 1'b0) && (busy === 1'b0) && (op_ready === 1'b1);
        break;
      end
      if (k > 0 && o.fu_cyc >= 0 && cyc == o.fu_cyc + k) begin
        fu_result_valid = 1'b1; fu_result = res; fu_result_flags = flg;
      end
      tick();
    end
    fu_result_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_cmp++; if ({op_ready, fu_data_valid, wb_valid, busy, fault} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {op_ready, fu_data_valid, wb_valid, busy, fault}); end
    n_cmp++; if ({fu_opcode, fu_data_a, fu_data_b, wb_dest, wb_data, wb_flags} !== 36'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {fu_opcode, fu_data_a, fu_data_b, wb_dest, wb_data, wb_flags}); end
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (op_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: op_ready=%b busy=%b want 1 0", op_ready, busy); end
  endtask

  task automatic test_reset_mid_wait();
    bit stray;
    op_valid = 1'b1; op_opcode = OP_DIV; op_a = 8'd100; op_b = 8'd7; op_dest = 4'd5;
    tick();
    op_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b1 || fu_data_a !== 8'd100) begin n_bad++; $display("FAIL rst_wait_pre: busy=%b a=%0d want 1 100", busy, fu_data_a); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({op_ready, fu_data_valid, wb_valid, busy, fault} !== 5'b0) begin n_bad++; $display("FAIL rst_wait_ctrl: got %b want 00000", {op_ready, fu_data_valid, wb_valid, busy, fault}); end
    n_cmp++; if ({fu_opcode, fu_data_a, fu_data_b, wb_dest, wb_data, wb_flags} !== 36'h0) begin n_bad++; $display("FAIL rst_wait_data: got %h want 0", {fu_opcode, fu_data_a, fu_data_b, wb_dest, wb_data, wb_flags}); end
    reset_n = 1'b1;
    tick();
    fu_result_valid = 1'b1; fu_result = 8'd14; fu_result_flags = 4'b0000;
    tick();
    fu_result_valid = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      tick();
    end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL rst_stale_result: got wb/busy activity=%b want 0", stray); end
  endtask

  task automatic test_div_normal();
    obs_t o;
    drive_op(OP_DIV, 8'd100, 8'd7, 4'd3, 3, 8'd14, 4'b0000, 0, o);
    n_cmp++; if (o.acc_rdy !== 1'b1) begin n_bad++; $display("FAIL div_op_ready: got %b want 1", o.acc_rdy); end
    n_cmp++; if (o.fu_cnt !== 1 || o.fu_cyc !== 1) begin n_bad++; $display("FAIL div_strobe: count=%0d cycle=%0d want 1 1", o.fu_cnt, o.fu_cyc); end
    n_cmp++; if ({o.fu_op, o.fu_a, o.fu_b} !== {OP_DIV, 8'd100, 8'd7}) begin n_bad++; $display("FAIL div_fu_operands: got %h want %h", {o.fu_op, o.fu_a, o.fu_b}, {OP_DIV, 8'd100, 8'd7}); end
    n_cmp++; if (o.wb_cyc !== 5) begin n_bad++; $display("FAIL div_wb_cycle: got %0d want 5", o.wb_cyc); end
    n_cmp++; if (o.wb_dat !== 8'd14 || o.wb_flg !== 4'b0000 || o.wb_dst !== 4'd3) begin n_bad++; $display("FAIL div_wb_payload: got %0d/%b/%0d want 14/0000/3", o.wb_dat, o.wb_flg, o.wb_dst); end
    n_cmp++; if (o.post_idle !== 1'b1) begin n_bad++; $display("FAIL div_post_idle: got %b want 1", o.post_idle); end
  endtask

  task automatic test_div_zero();
    obs_t o;
    drive_op(OP_REM, 8'd55, 8'd0, 4'd9, 3, 8'hAA, 4'b1111, 0, o);
    n_cmp++; if (o.fu_cnt !== 0) begin n_bad++; $display("FAIL dbz_no_issue: strobes=%0d want 0", o.fu_cnt); end
    n_cmp++; if (o.wb_cyc !== 1) begin n_bad++; $display("FAIL dbz_wb_cycle: got %0d want 1", o.wb_cyc); end
    n_cmp++; if (o.wb_dat !== 8'd0 || o.wb_flg !== 4'b1001 || o.wb_dst !== 4'd9) begin n_bad++; $display("FAIL dbz_payload: got %0d/%b/%0d want 0/1001/9", o.wb_dat, o.wb_flg, o.wb_dst); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    fault_clear = 1'b1;
    drive_op(OP_XOR, 8'h5A, 8'h0F, 4'd12, 2, 8'h55, 4'b0100, 9, o);
    fault_clear = 1'b0;
    n_cmp++; if (o.wb_cyc !== 4) begin n_bad++; $display("FAIL bp_wb_cycle: got %0d want 4", o.wb_cyc); end
    n_cmp++; if (o.stall_bad !== 1'b0) begin n_bad++; $display("FAIL bp_stable: instability=%b want 0", o.stall_bad); end
    n_cmp++; if (o.wb_dat !== 8'h55 || o.wb_flg !== 4'b0100 || o.wb_dst !== 4'd12) begin n_bad++; $display("FAIL bp_payload: got %h/%b/%0d want 55/0100/12", o.wb_dat, o.wb_flg, o.wb_dst); end
    n_cmp++; if (o.post_idle !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", o.post_idle); end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_op(OP_AND, 8'hF0, 8'h3C, 4'd1, 0, 8'h00, 4'b0000, 0, o);
    n_cmp++; if (o.fault_cyc !== 2 + TMO || o.wb_cyc !== -1) begin n_bad++; $display("FAIL tmo_fault_cycle: got %0d (wb %0d) want %0d", o.fault_cyc, o.wb_cyc, 2 + TMO); end
    n_cmp++; if (op_ready !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_state: ready=%b busy=%b wb=%b want 0 1 0", op_ready, busy, wb_valid); end
    fu_result_valid = 1'b1; fu_result = 8'h77; fu_result_flags = 4'b0001;
    tick();
    fu_result_valid = 1'b0;
    tick();
    n_cmp++; if (fault !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_late_result: fault=%b wb=%b want 1 0", fault, wb_valid); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_cmp++; if (fault !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_clear: fault=%b busy=%b ready=%b want 0 0 1", fault, busy, op_ready); end
  endtask

  task automatic test_race();
    obs_t o;
    drive_op(OP_OR, 8'hF0, 8'h0F, 4'd7, TMO, 8'hFF, 4'b0010, 0, o);
    n_cmp++; if (o.fault_cyc !== -1 || o.wb_cyc !== 2 + TMO) begin n_bad++; $display("FAIL race_timing: fault at %0d wb at %0d want -1 %0d", o.fault_cyc, o.wb_cyc, 2 + TMO); end
    n_cmp++; if (o.wb_dat !== 8'hFF || o.wb_flg !== 4'b0010) begin n_bad++; $display("FAIL race_payload: got %h/%b want ff/0010", o.wb_dat, o.wb_flg); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [3:0] opc, dest, flg;
    logic [7:0] a, b, res, e_dat;
    logic [3:0] e_flg;
    int k, stall, e_wb, e_fault, e_fu;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: opc = OP_AND; 1: opc = OP_OR; 2: opc = OP_XOR; 3: opc = OP_NOT;
        4: opc = OP_NEG; 5: opc = OP_DIV; default: opc = OP_REM;
      endcase
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      dest = 4'($urandom);
      flg = 4'($urandom);
      k = $urandom_range(1, TMO + 1);
      stall = $urandom_range(0, 3);
      res = alu_ref(opc, a, b);
      // Reference: zero divisor short-circuits, slow unit faults, else result after k
      if ((opc == OP_DIV || opc == OP_REM) && b == 8'h00) begin
        e_wb = 1; e_fault = -1; e_fu = 0; e_dat = 8'h00; e_flg = 4'b1001;
      end else if (k <= TMO) begin
        e_wb = 2 + k; e_fault = -1; e_fu = 1; e_dat = res; e_flg = flg;
      end else begin
        e_wb = -1; e_fault = 2 + TMO; e_fu = 1; e_dat = 8'h00; e_flg = 4'b0000;
      end
      drive_op(opc, a, b, dest, k, res, flg, stall, o);
      n_cmp++; if (o.wb_cyc !== e_wb || o.fault_cyc !== e_fault || o.fu_cnt !== e_fu) begin n_bad++; $display("FAIL rnd%0d_timing: wb=%0d fault=%0d fu=%0d want %0d %0d %0d", n, o.wb_cyc, o.fault_cyc, o.fu_cnt, e_wb, e_fault, e_fu); end
      if (e_fu == 1) begin
        n_cmp++; if ({o.fu_op, o.fu_a, o.fu_b} !== {opc, a, b}) begin n_bad++; $display("FAIL rnd%0d_fu_operands: got %h want %h", n, {o.fu_op, o.fu_a, o.fu_b}, {opc, a, b}); end
      end
      if (e_wb >= 0) begin
        n_cmp++; if (o.wb_dat !== e_dat || o.wb_flg !== e_flg || o.wb_dst !== dest || o.stall_bad !== 1'b0 || o.post_idle !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_wb: got %h/%b/%0d stall_bad=%b idle=%b want %h/%b/%0d 0 1", n, o.wb_dat, o.wb_flg, o.wb_dst, o.stall_bad, o.post_idle, e_dat, e_flg, dest); end
      end else begin
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n_cmp++; if (fault !== 1'b0 || op_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_clear: fault=%b ready=%b want 0 1", n, fault, op_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_div_normal();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
